// File: rtl/matmul_pkg.sv
// Shared types and constants for the MATMUL2 microcode-mode sequencer.
// Decode uses the opcode/funct3 constants to raise start_req/end_req.
package matmul_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'b00,
        ST_ENTER  = 2'b01,
        ST_MATMUL = 2'b10,
        ST_EXIT   = 2'b11
    } mm_state_e;

    localparam logic [6:0] MATMUL_OPCODE = 7'b1111010;
    localparam logic [2:0] F3_START      = 3'b000;
    localparam logic [2:0] F3_END        = 3'b111;

    // Fetch is pointed at the microcode ROM in these states.
    function automatic logic in_ucode(input mm_state_e s);
        return (s == ST_ENTER) || (s == ST_MATMUL);
    endfunction

endpackage

// File: rtl/matmul_wdt.sv
// Watchdog cycle counter for MATMUL mode; only built with MATMUL_WATCHDOG_EN.
// o_tc is high on the LIMIT-th enabled cycle after a clear.
module matmul_wdt #(
    parameter int LIMIT = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);
    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Terminal count one early so the exit edge is the LIMIT-th MATMUL cycle.
    assign o_tc = i_en && (r_cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/matmul_mode_ctrl.sv
// MATMUL2 mode sequencer: NORMAL -> ENTER -> MATMUL -> EXIT -> NORMAL.
// Optional forced-exit watchdog is built when MATMUL_WATCHDOG_EN is defined.
module matmul_mode_ctrl
    import matmul_pkg::*;
#(
    parameter logic [31:0] UCODE_BASE = 32'h0000_0000,
    parameter int          WDT_LIMIT  = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_req,
    input  logic        end_req,
    input  logic [31:0] pc_d,
    input  logic        stall_d,
    output logic        save_pc,
    output logic [31:0] pc_backup,
    output logic        im_sel,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        flush_fd,
    output logic        mode_active,
    output logic        illegal,
    output logic        wdt_fired
);
    mm_state_e   r_state;
    logic [31:0] r_pc_backup;
    logic        r_illegal;
    logic        r_wdt_fired;

    logic w_start_ok;
    logic w_end_ok;
    logic w_illegal_evt;
    logic w_wdt_exit;

    assign w_start_ok = (r_state == ST_NORMAL) && start_req && !stall_d;
    assign w_end_ok   = (r_state == ST_MATMUL) && end_req && !stall_d;

    // Start wins in NORMAL and end wins in MATMUL, so the loser is not flagged.
    assign w_illegal_evt = !stall_d &&
        (((r_state == ST_NORMAL) && end_req && !start_req) ||
         ((r_state == ST_MATMUL) && start_req && !end_req));

`ifdef MATMUL_WATCHDOG_EN
    logic w_wdt_tc;

    matmul_wdt #(
        .LIMIT (WDT_LIMIT)
    ) u_wdt (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_clr   (r_state == ST_ENTER),
        .i_en    (r_state == ST_MATMUL),
        .o_tc    (w_wdt_tc)
    );

    assign w_wdt_exit = w_wdt_tc && !w_end_ok;
`else
    logic w_unused_wdt_cfg;

    assign w_unused_wdt_cfg = (WDT_LIMIT > 0);
    assign w_wdt_exit       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= ST_NORMAL;
            r_pc_backup <= '0;
            r_illegal   <= 1'b0;
            r_wdt_fired <= 1'b0;
        end else begin
            if (w_illegal_evt) r_illegal <= 1'b1;
            case (r_state)
                ST_NORMAL: begin
                    if (w_start_ok) begin
                        r_pc_backup <= pc_d + 32'd4;
                        r_state     <= ST_ENTER;
                    end
                end
                ST_ENTER:  r_state <= ST_MATMUL;
                ST_MATMUL: begin
                    if (w_end_ok) begin
                        r_state <= ST_EXIT;
                    end else if (w_wdt_exit) begin
                        r_state     <= ST_EXIT;
                        r_wdt_fired <= 1'b1;
                    end
                end
                ST_EXIT:   r_state <= ST_NORMAL;
                default:   r_state <= ST_NORMAL;
            endcase
        end
    end

    // Redirect controls decode directly from state so fetch sees them this cycle.
    assign save_pc     = w_start_ok;
    assign pc_backup   = r_pc_backup;
    assign im_sel      = in_ucode(r_state);
    assign mode_active = in_ucode(r_state);
    assign redirect    = (r_state == ST_ENTER) || (r_state == ST_EXIT);
    assign flush_fd    = redirect;
    assign redirect_pc = (r_state == ST_ENTER) ? UCODE_BASE :
                         (r_state == ST_EXIT)  ? r_pc_backup : 32'h0;
    assign illegal     = r_illegal;
    assign wdt_fired   = r_wdt_fired;

endmodule

// File: doc/matmul_mode_ctrl.md
# matmul_mode_ctrl

Sequencer for the MATMUL2 microcode mode of the pipelined RISC-V core. It accepts STARTMATMUL2/ENDMATMUL requests from decode and saves the return PC. It drives the instruction-memory select, the fetch redirect and the front-end flush so the core enters the microcode ROM and returns cleanly. It sits beside the hazard unit and replaces the bare one-bit toggle FSM.

## Interface
Parameters:
- UCODE_BASE, 32'h0000_0000: fetch address of the first microcode instruction.
- WDT_LIMIT, 1024: maximum cycles allowed in MATMUL before a forced exit (watchdog build only).

Ports:
- clk  in  1  core clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low reset.
- start_req  in  1  decode holds STARTMATMUL2 (opcode 1111010, funct3 000).
- end_req  in  1  decode holds ENDMATMUL (opcode 1111010, funct3 111).
- pc_d  in  32  PC of the instruction in decode.
- stall_d  in  1  decode stalled; requests are not accepted while high.
- save_pc  out  1  combinational; high in the cycle a start is accepted.
- pc_backup  out  32  saved return address.
- im_sel  out  1  0 = program memory, 1 = microcode memory.
- redirect  out  1  forces PCF to redirect_pc at the next edge.
- redirect_pc  out  32  redirect target.
- flush_fd  out  1  flush the F and D pipeline registers.
- mode_active  out  1  state is ENTER or MATMUL.
- illegal  out  1  sticky; set by an end in NORMAL or a start in MATMUL.
- wdt_fired  out  1  sticky; forced exit occurred (tied 0 without the watchdog).

## Operation
- States: NORMAL, ENTER, MATMUL, EXIT (2-bit encoding).
- NORMAL: when start_req is high and stall_d is low, the start is accepted.
  - save_pc=1; pc_backup <= pc_d+4 (modulo 2^32); next state ENTER.
- ENTER (exactly 1 cycle): redirect=1, redirect_pc=UCODE_BASE, flush_fd=1, im_sel=1; next state MATMUL.
- MATMUL: im_sel=1. When end_req is high and stall_d is low, the end is accepted; next state EXIT.
- EXIT (exactly 1 cycle): redirect=1, redirect_pc=pc_backup, flush_fd=1, im_sel=0; next state NORMAL.
- Simultaneous start_req and end_req:
  - In NORMAL the start wins; the end is ignored with no illegal flag.
  - In MATMUL the end wins; no illegal flag.
- An end in NORMAL or a start in MATMUL (unstalled) is ignored and sets illegal.
- Requests during ENTER or EXIT are ignored without a flag, since they are flushed instructions.
- pc_backup changes only on an accepted start. It holds through MATMUL and EXIT.
- Reset (reset==0), including mid-MATMUL:
  - State returns to NORMAL.
  - Outputs clear: im_sel, redirect, flush_fd, save_pc, mode_active, illegal and wdt_fired go to 0; pc_backup goes to 0; redirect_pc reads 0.
  - No exit redirect is issued.

## Timing
- Start accepted at edge N. ENTER is active in cycle N+1 and the redirect takes effect at edge N+1, so PCF=UCODE_BASE in cycle N+2 with im_sel=1 from N+1.
- End accepted at edge M. PCF=pc_backup in cycle M+2; im_sel=0 from M+1.
- The instruction following STARTMATMUL2 in fetch is flushed and never executes.
- Minimum round trip is 4 cycles: accept, ENTER, MATMUL (≥1 cycle), EXIT.
- redirect, flush_fd and redirect_pc are pure functions of state; they are valid in the same cycle and have no extra register stage.

## Configuration
- MATMUL_WATCHDOG_EN defined:
  - A cycle counter clears on entry to ENTER and increments each MATMUL cycle.
  - When the counter reaches WDT_LIMIT in MATMUL, the block goes to EXIT as if an end had been accepted and sets wdt_fired.
  - A simultaneous end is treated as a normal end and does not set wdt_fired.
- MATMUL_WATCHDOG_EN undefined: no counter is built, wdt_fired is tied to 0, and MATMUL persists until end_req.

## Structure
- matmul_pkg holds:
  - the state enum typedef (NORMAL, ENTER, MATMUL, EXIT);
  - the MATMUL opcode 7'b1111010;
  - the funct3 constants for start (000) and end (111).
- One sub-module, matmul_wdt: counter, clear, enable and terminal-count output, instantiated only under MATMUL_WATCHDOG_EN.
- FSM and pc_backup register live in matmul_mode_ctrl.

## Test plan
- Reset, then start_req with pc_d=0x40 → save_pc=1; pc_backup=0x44; ENTER with redirect_pc=0x0; im_sel=1 next cycle.
- In MATMUL, end_req → EXIT with redirect_pc=0x44, flush_fd=1; NORMAL follows; im_sel=0.
- start_req with stall_d=1 for 3 cycles, then with stall_d=0 → accepted only on the unstalled cycle; pc_backup taken from pc_d of that cycle.
- end_req in NORMAL → no state change; illegal=1 and holds until reset. start_req+end_req in MATMUL → EXIT; illegal stays 0.
- reset=0 while in MATMUL → NORMAL next cycle; im_sel=0, pc_backup=0, no redirect.
- With MATMUL_WATCHDOG_EN, WDT_LIMIT=8, no end_req → EXIT after 8 MATMUL cycles with wdt_fired=1 and redirect_pc=pc_backup.
